// File: rtl/div_arb_pkg.sv
// Shared types and helpers for the divider arbiter: FSM states, id width and
// the round-robin pick function used to build the one-hot grant.
package div_arb_pkg;

   localparam int N_REQ_DFLT  = 4;
   localparam int ID_W        = $clog2(N_REQ_DFLT);
   localparam int DIV_LATENCY = 34;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_t;

   // One-hot pick of the first valid requester at or after ptr, wrapping at n (n <= 8).
   function automatic logic [7:0] rr_pick(input logic [7:0] valid,
                                          input logic [2:0] ptr,
                                          input int unsigned n);
      logic [7:0] grant;
      logic [2:0] idx;
      grant = '0;
      for (int unsigned k = 0; k < 8; k++) begin
         idx = 3'((32'(ptr) + k) % n);
         if (k < n && grant == '0 && valid[idx]) begin
            grant[idx] = 1'b1;
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/div_arbiter_divider.sv
// Iterative restoring divider: one quotient bit per clock, result pulse one
// cycle after the last step; a zero divisor answers immediately with an error.
module divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             data_valid_in,
   input  logic [WIDTH-1:0] dividend_in,
   input  logic [WIDTH-1:0] divisor_in,
   output logic             data_valid_out,
   output logic [WIDTH-1:0] quotient_out,
   output logic [WIDTH-1:0] remainder_out,
   output logic             error_out,
   output logic             busy_out
);

   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [5:0]       step_q, step_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   diff;

   always_comb begin
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = err_q;
      step_d    = step_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      rem_shift = {rem_q, quo_q[WIDTH-1]};
      diff      = rem_shift - {1'b0, dvs_q};
      if (data_valid_in) begin
         if (divisor_in == '0) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            err_d  = 1'b1;
            quo_d  = '0;
            rem_d  = '0;
         end else begin
            busy_d = 1'b1;
            err_d  = 1'b0;
            step_d = '0;
            quo_d  = dividend_in;
            rem_d  = '0;
            dvs_d  = divisor_in;
         end
      end else if (busy_q) begin
         // The quotient register doubles as the dividend shift register.
         if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_d = rem_shift[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
         end
         step_d = step_q + 6'd1;
         if (step_q == 6'(WIDTH - 1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         step_q <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
      end else begin
         busy_q <= busy_d;
         done_q <= done_d;
         err_q  <= err_d;
         step_q <= step_d;
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
      end
   end

   assign data_valid_out = done_q;
   assign quotient_out   = quo_q;
   assign remainder_out  = rem_q;
   assign error_out      = err_q;
   assign busy_out       = busy_q;

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one iterative divider between N_REQ clients,
// with a watchdog that flushes the divider when a result never comes back.
module div_arbiter
   import div_arb_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                     clk_in,
   input  logic                     rst_n_in,
   input  logic [N_REQ-1:0]         req_valid_in,
   input  logic [N_REQ*WIDTH-1:0]   req_dividend_in,
   input  logic [N_REQ*WIDTH-1:0]   req_divisor_in,
   output logic [N_REQ-1:0]         req_ready_out,
   output logic                     resp_valid_out,
   output logic [$clog2(N_REQ)-1:0] resp_id_out,
   output logic [WIDTH-1:0]         resp_quotient_out,
   output logic [WIDTH-1:0]         resp_remainder_out,
   output logic                     resp_error_out,
   output logic                     resp_timeout_out,
   output logic                     busy_out
);

   localparam int ID_BITS = $clog2(N_REQ);
   localparam int CNT_W   = $clog2(TIMEOUT) + 1;
   localparam logic [ID_BITS-1:0] LAST_ID  = ID_BITS'(N_REQ - 1);
   localparam logic [CNT_W-1:0]   FIRE_CNT = CNT_W'(TIMEOUT - 2);

   arb_state_t         state_q, state_d;
   logic [ID_BITS-1:0] rr_ptr_q, rr_ptr_d;
   logic [ID_BITS-1:0] id_q, id_d;
   logic [WIDTH-1:0]   dividend_q, dividend_d;
   logic [WIDTH-1:0]   divisor_q, divisor_d;
   logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [ID_BITS-1:0] resp_id_q, resp_id_d;
   logic [WIDTH-1:0]   resp_quot_q, resp_quot_d;
   logic [WIDTH-1:0]   resp_rem_q, resp_rem_d;
   logic               resp_err_q, resp_err_d;
   logic               resp_to_q, resp_to_d;

   logic [7:0]         pick_all;
   logic [N_REQ-1:0]   grant;
   logic [ID_BITS-1:0] grant_id;
   logic [WIDTH-1:0]   grant_dividend;
   logic [WIDTH-1:0]   grant_divisor;
   logic               flush;
   logic               div_start;
   logic               div_rst;
   logic               div_valid;
   logic [WIDTH-1:0]   div_quot;
   logic [WIDTH-1:0]   div_rem;
   logic               div_err;

   // Grant is only offered in IDLE and is forced low while reset is held.
   always_comb begin
      pick_all       = rr_pick(8'(req_valid_in), 3'(rr_ptr_q), N_REQ);
      grant          = (state_q == IDLE && rst_n_in) ? pick_all[N_REQ-1:0] : '0;
      grant_id       = '0;
      grant_dividend = '0;
      grant_divisor  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            grant_id       = ID_BITS'(i);
            grant_dividend = req_dividend_in[i*WIDTH +: WIDTH];
            grant_divisor  = req_divisor_in[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      id_d        = id_q;
      dividend_d  = dividend_q;
      divisor_d   = divisor_q;
      wait_cnt_d  = wait_cnt_q;
      resp_id_d   = resp_id_q;
      resp_quot_d = resp_quot_q;
      resp_rem_d  = resp_rem_q;
      resp_err_d  = resp_err_q;
      resp_to_d   = resp_to_q;
      flush       = 1'b0;
      div_start   = 1'b0;
      case (state_q)
         IDLE: begin
            if (|pick_all) begin
               id_d       = grant_id;
               dividend_d = grant_dividend;
               divisor_d  = grant_divisor;
               rr_ptr_d   = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            div_start  = 1'b1;
            wait_cnt_d = '0;
            state_d    = WAIT;
         end
         WAIT: begin
            // The count fires as its next value reaches TIMEOUT-1.
            wait_cnt_d = wait_cnt_q + 1'b1;
            if (div_valid) begin
               resp_id_d   = id_q;
               resp_quot_d = div_quot;
               resp_rem_d  = div_rem;
               resp_err_d  = div_err;
               resp_to_d   = 1'b0;
               state_d     = RESP;
            end else if (wait_cnt_q == FIRE_CNT) begin
               flush       = 1'b1;
               resp_id_d   = id_q;
               resp_quot_d = '0;
               resp_rem_d  = '0;
               resp_err_d  = 1'b1;
               resp_to_d   = 1'b1;
               state_d     = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         id_q        <= '0;
         dividend_q  <= '0;
         divisor_q   <= '0;
         wait_cnt_q  <= '0;
         resp_id_q   <= '0;
         resp_quot_q <= '0;
         resp_rem_q  <= '0;
         resp_err_q  <= 1'b0;
         resp_to_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         id_q        <= id_d;
         dividend_q  <= dividend_d;
         divisor_q   <= divisor_d;
         wait_cnt_q  <= wait_cnt_d;
         resp_id_q   <= resp_id_d;
         resp_quot_q <= resp_quot_d;
         resp_rem_q  <= resp_rem_d;
         resp_err_q  <= resp_err_d;
         resp_to_q   <= resp_to_d;
      end
   end

   assign div_rst = ~rst_n_in | flush;

   divider #(
      .WIDTH(WIDTH)
   ) u_div (
      .clk_in        (clk_in),
      .rst_in        (div_rst),
      .data_valid_in (div_start),
      .dividend_in   (dividend_q),
      .divisor_in    (divisor_q),
      .data_valid_out(div_valid),
      .quotient_out  (div_quot),
      .remainder_out (div_rem),
      .error_out     (div_err),
      .busy_out      ()
   );

   assign req_ready_out      = grant;
   assign resp_valid_out     = (state_q == RESP);
   assign resp_id_out        = resp_id_q;
   assign resp_quotient_out  = resp_quot_q;
   assign resp_remainder_out = resp_rem_q;
   assign resp_error_out     = resp_err_q;
   assign resp_timeout_out   = resp_to_q;
   assign busy_out           = (state_q != IDLE);

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter: each scenario drives requests and checks
// grants, response timing and result fields against hand-computed values.
module tb_div_arbiter;
   import div_arb_pkg::*;

   localparam int W  = 32;
   localparam int N  = 4;
   localparam int TO = 64;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      valid;
   logic [N*W-1:0]    dvd;
   logic [N*W-1:0]    dvs;
   logic [N-1:0]      ready;
   logic              resp_valid;
   logic [ID_W-1:0]   resp_id;
   logic [W-1:0]      resp_q;
   logic [W-1:0]      resp_r;
   logic              resp_err;
   logic              resp_to;
   logic              busy;

   int vectors = 0;
   int errors  = 0;

   div_arbiter #(.WIDTH(W), .N_REQ(N), .TIMEOUT(TO)) dut (
      .clk_in            (clk),
      .rst_n_in          (rst_n),
      .req_valid_in      (valid),
      .req_dividend_in   (dvd),
      .req_divisor_in    (dvs),
      .req_ready_out     (ready),
      .resp_valid_out    (resp_valid),
      .resp_id_out       (resp_id),
      .resp_quotient_out (resp_q),
      .resp_remainder_out(resp_r),
      .resp_error_out    (resp_err),
      .resp_timeout_out  (resp_to),
      .busy_out          (busy)
   );

   always #5 clk = ~clk;

   // Issue one request from requester id and wait for its response; only observes.
   task automatic do_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int gwait, output int lat, output logic [N-1:0] gnt,
                        output logic [ID_W-1:0] rid, output logic [W-1:0] q,
                        output logic [W-1:0] r, output logic err, output logic to);
      gwait = -1; lat = -1; gnt = '0; rid = '0; q = '0; r = '0; err = 1'b0; to = 1'b0;
      @(negedge clk);
      dvd[id*W +: W] = a;
      dvs[id*W +: W] = b;
      valid[id] = 1'b1;
      #1;
      for (int c = 0; c < 100; c++) begin
         if (ready != '0) begin
            gwait = c;
            gnt = ready;
            break;
         end
         @(negedge clk); #1;
      end
      if (gwait < 0) begin
         valid[id] = 1'b0;
         return;
      end
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (c == 1) valid[id] = 1'b0;
         #1;
         if (resp_valid) begin
            lat = c; rid = resp_id; q = resp_q; r = resp_r; err = resp_err; to = resp_to;
            break;
         end
      end
   endtask

   task automatic apply_reset;
      @(negedge clk);
      rst_n = 1'b0;
      valid = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst_n = 1'b0;
      valid = '1;
      #1;
      vectors++;
      if ({busy, resp_valid, ready, resp_id, resp_q, resp_r, resp_err, resp_to} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got busy=%b rv=%b rdy=%b id=%0d q=%h r=%h e=%b t=%b, expected all 0",
                  busy, resp_valid, ready, resp_id, resp_q, resp_r, resp_err, resp_to);
      end
      valid = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single;
      @(negedge clk);
      dvd[2*W +: W] = 32'd100;
      dvs[2*W +: W] = 32'd7;
      valid = 4'b0100;
      #1;
      vectors++;
      if (ready !== 4'b0100) begin
         errors++; $display("[TB] FAIL t1_grant: got %b expected 0100", ready);
      end
      for (int c = 1; c <= 36; c++) begin
         @(negedge clk);
         if (c == 1) valid = '0;
         #1;
         vectors++;
         if (busy !== (c <= DIV_LATENCY + 1)) begin
            errors++; $display("[TB] FAIL t1_busy cycle %0d: got %b expected %b", c, busy, c <= 35);
         end
         vectors++;
         if (resp_valid !== (c == DIV_LATENCY + 1)) begin
            errors++; $display("[TB] FAIL t1_resp_valid cycle %0d: got %b", c, resp_valid);
         end
         if (c == DIV_LATENCY + 1) begin
            vectors++;
            if ({resp_id, resp_q, resp_r, resp_err} !== {2'd2, 32'd14, 32'd2, 1'b0}) begin
               errors++;
               $display("[TB] FAIL t1_result: got id=%0d q=%0d r=%0d e=%b expected id=2 q=14 r=2 e=0",
                        resp_id, resp_q, resp_r, resp_err);
            end
         end
      end
   endtask

   task automatic test_div_zero;
      int gw, lat; logic [N-1:0] g; logic [ID_W-1:0] id; logic [W-1:0] q, r; logic e, t;
      do_op(1, 32'd55, 32'd0, gw, lat, g, id, q, r, e, t);
      vectors++;
      if (g !== 4'b0010 || lat !== 3) begin
         errors++; $display("[TB] FAIL t2_zero_timing: grant=%b lat=%0d expected 0010 lat=3", g, lat);
      end
      vectors++;
      if ({id, q, r, e, t} !== {2'd1, 32'd0, 32'd0, 1'b1, 1'b0}) begin
         errors++; $display("[TB] FAIL t2_zero_result: id=%0d q=%0d r=%0d e=%b t=%b expected 1 0 0 1 0", id, q, r, e, t);
      end
      do_op(3, 32'd8, 32'd2, gw, lat, g, id, q, r, e, t);
      vectors++;
      if (gw !== 0 || g !== 4'b1000) begin
         errors++; $display("[TB] FAIL t2_next_grant: wait=%0d grant=%b expected wait=0 grant=1000", gw, g);
      end
      vectors++;
      if ({lat, id, q, r, e} !== {32'd35, 2'd3, 32'd4, 32'd0, 1'b0}) begin
         errors++; $display("[TB] FAIL t2_next_result: lat=%0d id=%0d q=%0d r=%0d e=%b expected 35 3 4 0 0", lat, id, q, r, e);
      end
   endtask

   task automatic test_round_robin;
      logic [W-1:0] exp_q [4];
      logic [W-1:0] exp_r [4];
      int gw, lat, eid;
      logic [N-1:0] g;
      exp_q[0] = 32'hFFFF_FFFF; exp_r[0] = 32'd0;
      exp_q[1] = 32'd3;         exp_r[1] = 32'd1;
      exp_q[2] = 32'd0;         exp_r[2] = 32'd7;
      exp_q[3] = 32'h0800_0000; exp_r[3] = 32'd0;
      apply_reset();
      @(negedge clk);
      dvd = {32'h8000_0000, 32'd7, 32'd10, 32'hFFFF_FFFF};
      dvs = {32'h10,        32'd9, 32'd3,  32'd1};
      valid = 4'b1111;
      #1;
      for (int k = 0; k < 5; k++) begin
         eid = k % 4;
         if (k > 0) begin @(negedge clk); #1; end
         gw = -1; g = '0;
         for (int c = 0; c < 100; c++) begin
            if (ready != '0) begin gw = c; g = ready; break; end
            @(negedge clk); #1;
         end
         vectors++;
         if (gw !== 0 || g !== 4'(1 << eid)) begin
            errors++; $display("[TB] FAIL t3_grant_%0d: wait=%0d grant=%b expected wait=0 id=%0d", k, gw, g, eid);
         end
         lat = -1;
         for (int c = 1; c <= 200; c++) begin
            @(negedge clk); #1;
            if (resp_valid) begin lat = c; break; end
         end
         vectors++;
         if (lat !== 35 || resp_id !== 2'(eid) || resp_q !== exp_q[eid] || resp_r !== exp_r[eid]) begin
            errors++;
            $display("[TB] FAIL t3_result_%0d: lat=%0d id=%0d q=%h r=%h expected 35 %0d %h %h",
                     k, lat, resp_id, resp_q, resp_r, eid, exp_q[eid], exp_r[eid]);
         end
      end
      valid = '0;
   endtask

   task automatic test_watchdog;
      int gw, lat; logic [N-1:0] g; logic [ID_W-1:0] id; logic [W-1:0] q, r; logic e, t;
      force dut.div_valid = 1'b0;
      do_op(0, 32'd20, 32'd3, gw, lat, g, id, q, r, e, t);
      release dut.div_valid;
      vectors++;
      if (lat !== TO + 1) begin
         errors++; $display("[TB] FAIL t4_wd_latency: got %0d expected %0d", lat, TO + 1);
      end
      vectors++;
      if ({id, q, r, e, t} !== {2'd0, 32'd0, 32'd0, 1'b1, 1'b1}) begin
         errors++; $display("[TB] FAIL t4_wd_result: id=%0d q=%0d r=%0d e=%b t=%b expected 0 0 0 1 1", id, q, r, e, t);
      end
      do_op(2, 32'd9, 32'd2, gw, lat, g, id, q, r, e, t);
      vectors++;
      if ({lat, id, q, r, e, t} !== {32'd35, 2'd2, 32'd4, 32'd1, 1'b0, 1'b0}) begin
         errors++; $display("[TB] FAIL t4_recover: lat=%0d id=%0d q=%0d r=%0d e=%b t=%b expected 35 2 4 1 0 0", lat, id, q, r, e, t);
      end
   endtask

   task automatic test_mid_reset;
      int gw, lat, stray; logic [N-1:0] g; logic [ID_W-1:0] id; logic [W-1:0] q, r; logic e, t;
      @(negedge clk);
      dvd[0 +: W] = 32'd1000;
      dvs[0 +: W] = 32'd3;
      valid[0] = 1'b1;
      #1;
      gw = -1;
      for (int c = 0; c < 100; c++) begin
         if (ready[0]) begin gw = c; break; end
         @(negedge clk); #1;
      end
      vectors++;
      if (gw < 0) begin
         errors++; $display("[TB] FAIL t5_grant: got no grant, expected requester 0");
      end
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) valid[0] = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({busy, resp_valid, ready, resp_id, resp_q, resp_r, resp_err, resp_to} !== '0) begin
         errors++;
         $display("[TB] FAIL t5_async_reset: busy=%b rv=%b q=%h r=%h e=%b expected all 0", busy, resp_valid, resp_q, resp_r, resp_err);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      stray = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk); #1;
         if (resp_valid) stray++;
      end
      vectors++;
      if (stray !== 0) begin
         errors++; $display("[TB] FAIL t5_stale_resp: got %0d pulses expected 0", stray);
      end
      do_op(1, 32'd6, 32'd4, gw, lat, g, id, q, r, e, t);
      vectors++;
      if ({lat, id, q, r, e} !== {32'd35, 2'd1, 32'd1, 32'd2, 1'b0}) begin
         errors++; $display("[TB] FAIL t5_fresh_op: lat=%0d id=%0d q=%0d r=%0d e=%b expected 35 1 1 2 0", lat, id, q, r, e);
      end
   endtask

   task automatic test_drop_valid;
      int gw, resp_cnt, g3_cnt; logic [ID_W-1:0] first_id; logic [W-1:0] first_q, first_r;
      @(negedge clk);
      dvd[0 +: W] = 32'd50;
      dvs[0 +: W] = 32'd5;
      dvd[3*W +: W] = 32'd77;
      dvs[3*W +: W] = 32'd7;
      valid = 4'b0001;
      #1;
      gw = -1;
      for (int c = 0; c < 100; c++) begin
         if (ready != '0) begin gw = c; break; end
         @(negedge clk); #1;
      end
      vectors++;
      if (gw < 0 || ready !== 4'b0001) begin
         errors++; $display("[TB] FAIL t6_grant0: wait=%0d grant=%b expected 0001", gw, ready);
      end
      resp_cnt = 0; g3_cnt = 0; first_id = '1; first_q = '1; first_r = '1;
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         if (c == 1)  valid[0] = 1'b0;
         if (c == 2)  valid[3] = 1'b1;
         if (c == 10) valid[3] = 1'b0;
         #1;
         if (ready[3]) g3_cnt++;
         if (resp_valid) begin
            if (resp_cnt == 0) begin first_id = resp_id; first_q = resp_q; first_r = resp_r; end
            resp_cnt++;
         end
      end
      vectors++;
      if (g3_cnt !== 0 || resp_cnt !== 1) begin
         errors++; $display("[TB] FAIL t6_skip3: grants3=%0d responses=%0d expected 0 and 1", g3_cnt, resp_cnt);
      end
      vectors++;
      if ({first_id, first_q, first_r} !== {2'd0, 32'd10, 32'd0}) begin
         errors++; $display("[TB] FAIL t6_result: id=%0d q=%0d r=%0d expected 0 10 0", first_id, first_q, first_r);
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "[TB] global timeout");
   end

   initial begin
      rst_n = 1'b0;
      valid = '0;
      dvd   = '0;
      dvs   = '0;
      test_reset();
      test_single();
      test_div_zero();
      test_round_robin();
      test_watchdog();
      test_mid_reset();
      test_drop_valid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
